// File: rtl/rv_load_store_unit.sv
// rv_load_store_unit
//   Multi-cycle load/store sequencer sitting between the core control FSM and
//   the data memory bus. A single request is accepted from control, decoded
//   into a byte size, aligned onto the bus word, and pushed through a
//   request/grant/response handshake. Loads come back sign- or zero-extended.
//   Misaligned, illegal-size, bus-error and timeout faults end the transfer
//   with a fault pulse alongside done_o.
//
// Ports
//   clk_i, reset_ni          clock, asynchronous active-low reset
//   start_i                  request strobe, only honoured while idle
//   write_i                  1 = store, 0 = load
//   funct3_i                 RISC-V size/sign field
//   addr_i, wdata_i          byte address and LSB-justified store data
//   busy_o                   high whenever the unit is not idle
//   done_o                   one-cycle completion pulse
//   rdata_o                  extended load result, held until the next done_o
//   fault_o, fault_cause_o   fault pulse and cause (01 misaligned,
//                            10 illegal size, 11 bus error/timeout)
//   bus_req_o .. bus_be_o    bus request side (word address, shifted data,
//                            byte enables)
//   bus_gnt_i                bus accepted the request
//   bus_rvalid_i             response valid (load data or store acknowledge)
//   bus_rdata_i, bus_err_i   response data and error flag

module rv_load_store_unit #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic                start_i,
    input  logic                write_i,
    input  logic [2:0]          funct3_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [XLEN-1:0]     wdata_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [XLEN-1:0]     rdata_o,
    output logic                fault_o,
    output logic [1:0]          fault_cause_o,
    output logic                bus_req_o,
    output logic                bus_we_o,
    output logic [ADDR_W-1:0]   bus_addr_o,
    output logic [XLEN-1:0]     bus_wdata_o,
    output logic [XLEN/8-1:0]   bus_be_o,
    input  logic                bus_gnt_i,
    input  logic                bus_rvalid_i,
    input  logic [XLEN-1:0]     bus_rdata_i,
    input  logic                bus_err_i
);

    localparam int BE_W  = XLEN / 8;
    localparam int OFF   = $clog2(BE_W);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_SIZE     = 2'b10;
    localparam logic [1:0] CAUSE_BUS      = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic                write_q, write_d;
    logic                unsigned_q, unsigned_d;
    logic [1:0]          size_q, size_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                fault_q, fault_d;
    logic [1:0]          cause_q, cause_d;
    logic [XLEN-1:0]     rdata_q, rdata_d;

    logic [1:0]          reqSize;
    logic                reqUnsigned;
    logic                reqIllegal;
    logic                reqMisaligned;
    logic [OFF-1:0]      sizeMask;
    logic [OFF-1:0]      byteOff;
    logic [BE_W-1:0]     beMask;
    logic [XLEN-1:0]     loadShifted;
    logic [XLEN-1:0]     loadExt;
    logic                loadSign;
    logic                busActive;
    logic                timeoutHit;

    // Decode the incoming request into log2(size), signedness and legality.
    // Size is kept as log2 bytes so it doubles as the alignment mask width.
    always_comb begin
        reqSize     = 2'd0;
        reqUnsigned = 1'b0;
        reqIllegal  = 1'b0;
        if (write_i) begin
            reqSize    = funct3_i[1:0];
            reqIllegal = funct3_i[2] || ((funct3_i[1:0] == 2'b11) && (XLEN == 32));
        end else begin
            case (funct3_i)
                3'b000: reqSize = 2'd0;
                3'b001: reqSize = 2'd1;
                3'b010: reqSize = 2'd2;
                3'b100: begin reqSize = 2'd0; reqUnsigned = 1'b1; end
                3'b101: begin reqSize = 2'd1; reqUnsigned = 1'b1; end
                3'b011: begin reqSize = 2'd3; reqIllegal = (XLEN == 32); end
                3'b110: begin
                    reqSize     = 2'd2;
                    reqUnsigned = 1'b1;
                    reqIllegal  = (XLEN == 32);
                end
                default: reqIllegal = 1'b1;
            endcase
        end
        for (int i = 0; i < OFF; i++) begin
            sizeMask[i] = (i < int'(reqSize));
        end
        reqMisaligned = |(addr_i[OFF-1:0] & sizeMask);
    end

    // Lane alignment for the registered request and load-data extraction.
    always_comb begin
        byteOff = addr_q[OFF-1:0];
        for (int i = 0; i < BE_W; i++) begin
            beMask[i] = (i < (int'(1) << size_q));
        end
        loadShifted = bus_rdata_i >> {byteOff, 3'b000};
        case (size_q)
            2'd0:    loadSign = loadShifted[7];
            2'd1:    loadSign = loadShifted[15];
            2'd2:    loadSign = loadShifted[31];
            default: loadSign = loadShifted[XLEN-1];
        endcase
        loadSign = loadSign & ~unsigned_q;
        loadExt  = loadShifted;
        for (int i = 0; i < XLEN; i++) begin
            if (i >= (8 << size_q)) begin
                loadExt[i] = loadSign;
            end
        end
    end

    // The abort fires on the last permitted REQ/RESP cycle so the bus sees at
    // most TIMEOUT cycles of activity. A grant in that same cycle loses to the
    // abort, but a response in that cycle still completes normally.
    assign timeoutHit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    // Next-state and request-field capture.
    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        unsigned_d = unsigned_q;
        size_d     = size_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        fault_d    = fault_q;
        cause_d    = cause_q;
        rdata_d    = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    write_d    = write_i;
                    unsigned_d = reqUnsigned;
                    size_d     = reqSize;
                    addr_d     = addr_i;
                    wdata_d    = wdata_i;
                    cnt_d      = '0;
                    fault_d    = 1'b0;
                    cause_d    = 2'b00;
                    state_d    = S_REQ;
                    if (reqIllegal) begin
                        fault_d = 1'b1;
                        cause_d = CAUSE_SIZE;
                        state_d = S_DONE;
                    end else if (reqMisaligned) begin
                        fault_d = 1'b1;
                        cause_d = CAUSE_MISALIGN;
                        state_d = S_DONE;
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (timeoutHit) begin
                    fault_d = 1'b1;
                    cause_d = CAUSE_BUS;
                    state_d = S_DONE;
                end else if (bus_gnt_i) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus_rvalid_i) begin
                    if (bus_err_i) begin
                        fault_d = 1'b1;
                        cause_d = CAUSE_BUS;
                    end else if (!write_q) begin
                        rdata_d = loadExt;
                    end
                    state_d = S_DONE;
                end else if (timeoutHit) begin
                    fault_d = 1'b1;
                    cause_d = CAUSE_BUS;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and request registers; reset aborts any transfer immediately.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= S_IDLE;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            size_q     <= 2'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            fault_q    <= 1'b0;
            cause_q    <= 2'b00;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            unsigned_q <= unsigned_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            fault_q    <= fault_d;
            cause_q    <= cause_d;
            rdata_q    <= rdata_d;
        end
    end

    // Bus fields are only driven while a transfer is on the bus so that an
    // idle or faulted unit presents all-zero outputs.
    assign busActive     = (state_q == S_REQ) || (state_q == S_RESP);
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = (state_q == S_DONE);
    assign fault_o       = done_o & fault_q;
    assign fault_cause_o = fault_o ? cause_q : 2'b00;
    assign rdata_o       = rdata_q;
    assign bus_req_o     = (state_q == S_REQ);
    assign bus_we_o      = busActive & write_q;
    assign bus_addr_o    = busActive ? (addr_q & ~ADDR_W'(BE_W - 1)) : '0;
    assign bus_be_o      = busActive ? (beMask << byteOff) : '0;
    assign bus_wdata_o   = busActive ? (wdata_q << {byteOff, 3'b000}) : '0;

endmodule

// File: tb/tb_rv_load_store_unit.sv
// tb_rv_load_store_unit
//   Directed bench for rv_load_store_unit. Instance "a" is RV32 with a short
//   timeout of 4 cycles; instance "b" is RV64 with the default timeout.
//   Each task drives one scenario and compares outputs against hand-computed
//   values. Inputs change on the falling clock edge, outputs are sampled there.

module tb_rv_load_store_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // RV32 instance signals
    logic        aRstN, aStart, aWrite, aGnt, aRvalid, aErr;
    logic [2:0]  aFunct3;
    logic [31:0] aAddr, aWdata, aBusRdata;
    logic        aBusy, aDone, aFault, aReq, aWe;
    logic [1:0]  aCause;
    logic [31:0] aRdata, aBusAddr, aBusWdata;
    logic [3:0]  aBe;

    // RV64 instance signals
    logic        bRstN, bStart, bWrite, bGnt, bRvalid, bErr;
    logic [2:0]  bFunct3;
    logic [31:0] bAddr, bBusAddr;
    logic [63:0] bWdata, bBusRdata, bRdata, bBusWdata;
    logic        bBusy, bDone, bFault, bReq, bWe;
    logic [1:0]  bCause;
    logic [7:0]  bBe;

    rv_load_store_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) dutA (
        .clk_i(clk), .reset_ni(aRstN), .start_i(aStart), .write_i(aWrite),
        .funct3_i(aFunct3), .addr_i(aAddr), .wdata_i(aWdata),
        .busy_o(aBusy), .done_o(aDone), .rdata_o(aRdata), .fault_o(aFault),
        .fault_cause_o(aCause), .bus_req_o(aReq), .bus_we_o(aWe),
        .bus_addr_o(aBusAddr), .bus_wdata_o(aBusWdata), .bus_be_o(aBe),
        .bus_gnt_i(aGnt), .bus_rvalid_i(aRvalid), .bus_rdata_i(aBusRdata),
        .bus_err_i(aErr)
    );

    rv_load_store_unit #(.XLEN(64), .ADDR_W(32), .TIMEOUT(255)) dutB (
        .clk_i(clk), .reset_ni(bRstN), .start_i(bStart), .write_i(bWrite),
        .funct3_i(bFunct3), .addr_i(bAddr), .wdata_i(bWdata),
        .busy_o(bBusy), .done_o(bDone), .rdata_o(bRdata), .fault_o(bFault),
        .fault_cause_o(bCause), .bus_req_o(bReq), .bus_we_o(bWe),
        .bus_addr_o(bBusAddr), .bus_wdata_o(bBusWdata), .bus_be_o(bBe),
        .bus_gnt_i(bGnt), .bus_rvalid_i(bRvalid), .bus_rdata_i(bBusRdata),
        .bus_err_i(bErr)
    );

    // Pulse start for one cycle; returns at the falling edge of cycle 1.
    task automatic aIssue(input logic w, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        aStart = 1'b1; aWrite = w; aFunct3 = f3; aAddr = addr; aWdata = wd;
        @(negedge clk);
        aStart = 1'b0;
    endtask

    task automatic bIssue(input logic [2:0] f3, input logic [31:0] addr);
        @(negedge clk);
        bStart = 1'b1; bWrite = 1'b0; bFunct3 = f3; bAddr = addr; bWdata = '0;
        @(negedge clk);
        bStart = 1'b0;
    endtask

    // From cycle 1: grant now, respond next cycle; returns in cycle 3.
    task automatic aBusCycle(input logic [31:0] rd, input logic err);
        aGnt = 1'b1;
        @(negedge clk);
        aGnt = 1'b0; aRvalid = 1'b1; aBusRdata = rd; aErr = err;
        @(negedge clk);
        aRvalid = 1'b0; aErr = 1'b0;
    endtask

    task automatic bBusCycle(input logic [63:0] rd);
        bGnt = 1'b1;
        @(negedge clk);
        bGnt = 1'b0; bRvalid = 1'b1; bBusRdata = rd;
        @(negedge clk);
        bRvalid = 1'b0;
    endtask

    task automatic test_reset;
        aRstN = 1'b0; bRstN = 1'b0;
        aStart = 0; aWrite = 0; aFunct3 = 0; aAddr = 0; aWdata = 0;
        aGnt = 0; aRvalid = 0; aErr = 0; aBusRdata = 0;
        bStart = 0; bWrite = 0; bFunct3 = 0; bAddr = 0; bWdata = 0;
        bGnt = 0; bRvalid = 0; bErr = 0; bBusRdata = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({aBusy, aDone, aFault, aCause, aReq, aWe} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_a_ctrl: got %b expected 0000000",
                     {aBusy, aDone, aFault, aCause, aReq, aWe});
        end
        checks++;
        if ({aRdata, aBusAddr, aBusWdata, aBe} !== 100'b0) begin
            errors++;
            $display("[TB] FAIL reset_a_data: rdata %h addr %h wdata %h be %b expected all 0",
                     aRdata, aBusAddr, aBusWdata, aBe);
        end
        checks++;
        if ({bBusy, bDone, bReq, bRdata} !== 67'b0) begin
            errors++;
            $display("[TB] FAIL reset_b: busy %b done %b req %b rdata %h expected all 0",
                     bBusy, bDone, bReq, bRdata);
        end
        aRstN = 1'b1; bRstN = 1'b1;
    endtask

    task automatic test_load_word;
        aIssue(1'b0, 3'b010, 32'h100, 32'h0);
        checks++;
        if ({aReq, aWe, aBe, aBusAddr, aBusy} !== {1'b1, 1'b0, 4'b1111, 32'h100, 1'b1}) begin
            errors++;
            $display("[TB] FAIL lw_req: req %b we %b be %b addr %h busy %b expected 1 0 1111 00000100 1",
                     aReq, aWe, aBe, aBusAddr, aBusy);
        end
        aGnt = 1'b1;
        @(negedge clk);
        aGnt = 1'b0;
        checks++;
        if ({aReq, aBusy, aDone} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL lw_resp_wait: req/busy/done %b expected 010", {aReq, aBusy, aDone});
        end
        aRvalid = 1'b1; aBusRdata = 32'hDEADBEEF;
        @(negedge clk);
        aRvalid = 1'b0;
        checks++;
        if ({aDone, aFault, aCause, aRdata} !== {1'b1, 1'b0, 2'b00, 32'hDEADBEEF}) begin
            errors++;
            $display("[TB] FAIL lw_done: done %b fault %b cause %b rdata %h expected 1 0 00 deadbeef",
                     aDone, aFault, aCause, aRdata);
        end
        @(negedge clk);
        checks++;
        if ({aDone, aBusy, aRdata} !== {2'b00, 32'hDEADBEEF}) begin
            errors++;
            $display("[TB] FAIL lw_after: done %b busy %b rdata %h expected 0 0 deadbeef",
                     aDone, aBusy, aRdata);
        end
    endtask

    task automatic test_load_byte;
        aIssue(1'b0, 3'b000, 32'h103, 32'h0);
        checks++;
        if ({aBe, aBusAddr} !== {4'b1000, 32'h100}) begin
            errors++;
            $display("[TB] FAIL lb_be: be %b addr %h expected 1000 00000100", aBe, aBusAddr);
        end
        aBusCycle(32'h80112233, 1'b0);
        checks++;
        if ({aDone, aRdata} !== {1'b1, 32'hFFFFFF80}) begin
            errors++;
            $display("[TB] FAIL lb_data: done %b rdata %h expected 1 ffffff80", aDone, aRdata);
        end
        aIssue(1'b0, 3'b100, 32'h103, 32'h0);
        aBusCycle(32'h80112233, 1'b0);
        checks++;
        if ({aDone, aRdata} !== {1'b1, 32'h00000080}) begin
            errors++;
            $display("[TB] FAIL lbu_data: done %b rdata %h expected 1 00000080", aDone, aRdata);
        end
        aIssue(1'b0, 3'b101, 32'h102, 32'h0);
        aBusCycle(32'h9ABC1234, 1'b0);
        checks++;
        if (aRdata !== 32'h00009ABC) begin
            errors++;
            $display("[TB] FAIL lhu_data: rdata %h expected 00009abc", aRdata);
        end
        aIssue(1'b0, 3'b001, 32'h102, 32'h0);
        aBusCycle(32'h9ABC1234, 1'b0);
        checks++;
        if (aRdata !== 32'hFFFF9ABC) begin
            errors++;
            $display("[TB] FAIL lh_data: rdata %h expected ffff9abc", aRdata);
        end
        // restore the value later tests rely on
        aIssue(1'b0, 3'b100, 32'h103, 32'h0);
        aBusCycle(32'h80112233, 1'b0);
    endtask

    task automatic test_store_half;
        aIssue(1'b1, 3'b001, 32'h102, 32'h0000ABCD);
        checks++;
        if ({aReq, aWe, aBe, aBusWdata, aBusAddr} !==
            {1'b1, 1'b1, 4'b1100, 32'hABCD0000, 32'h100}) begin
            errors++;
            $display("[TB] FAIL sh_req: req %b we %b be %b wdata %h addr %h expected 1 1 1100 abcd0000 00000100",
                     aReq, aWe, aBe, aBusWdata, aBusAddr);
        end
        aBusCycle(32'hFFFFFFFF, 1'b0);
        checks++;
        if ({aDone, aFault, aRdata} !== {1'b1, 1'b0, 32'h00000080}) begin
            errors++;
            $display("[TB] FAIL sh_done: done %b fault %b rdata %h expected 1 0 00000080",
                     aDone, aFault, aRdata);
        end
    endtask

    task automatic test_faults_at_accept;
        logic [37:0] table_v [5];
        logic [37:0] row;
        // {write, funct3, addr, cause}
        table_v[0] = {1'b0, 3'b010, 32'h101, 2'b01};
        table_v[1] = {1'b0, 3'b011, 32'h100, 2'b10};
        table_v[2] = {1'b0, 3'b011, 32'h101, 2'b10};
        table_v[3] = {1'b1, 3'b100, 32'h100, 2'b10};
        table_v[4] = {1'b1, 3'b010, 32'h102, 2'b01};
        for (int i = 0; i < 5; i++) begin
            row = table_v[i];
            aIssue(row[37], row[36:34], row[33:2], 32'h0);
            checks++;
            if ({aDone, aFault, aCause, aReq} !== {1'b1, 1'b1, row[1:0], 1'b0}) begin
                errors++;
                $display("[TB] FAIL fault_row%0d: done %b fault %b cause %b req %b expected 1 1 %b 0",
                         i, aDone, aFault, aCause, aReq, row[1:0]);
            end
            @(negedge clk);
            checks++;
            if ({aDone, aFault, aCause, aBusy} !== 5'b0) begin
                errors++;
                $display("[TB] FAIL fault_clear%0d: done %b fault %b cause %b busy %b expected all 0",
                         i, aDone, aFault, aCause, aBusy);
            end
        end
    endtask

    task automatic test_bus_error;
        aIssue(1'b0, 3'b010, 32'h104, 32'h0);
        aBusCycle(32'hDEADBEEF, 1'b1);
        checks++;
        if ({aDone, aFault, aCause, aRdata} !== {1'b1, 1'b1, 2'b11, 32'h00000080}) begin
            errors++;
            $display("[TB] FAIL bus_err: done %b fault %b cause %b rdata %h expected 1 1 11 00000080",
                     aDone, aFault, aCause, aRdata);
        end
    endtask

    task automatic test_timeout;
        int  reqCycles;
        bit  seen;
        logic [2:0] doneFlags;
        reqCycles = 0;
        seen      = 0;
        doneFlags = 3'b000;
        aIssue(1'b0, 3'b010, 32'h200, 32'h0);
        for (int i = 0; i < 12 && !seen; i++) begin
            if (aReq) reqCycles++;
            if (aDone) begin
                seen      = 1;
                doneFlags = {aFault, aCause};
            end else begin
                @(negedge clk);
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL timeout_wait: done_o never seen within 12 cycles, expected by cycle 5");
        end
        checks++;
        if (reqCycles != 4) begin
            errors++;
            $display("[TB] FAIL timeout_req_len: got %0d cycles expected 4", reqCycles);
        end
        checks++;
        if (doneFlags !== 3'b111) begin
            errors++;
            $display("[TB] FAIL timeout_cause: fault/cause %b expected 111", doneFlags);
        end
        @(negedge clk);
        aRvalid = 1'b1; aBusRdata = 32'h12345678;
        @(negedge clk);
        aRvalid = 1'b0;
        checks++;
        if ({aBusy, aDone, aFault, aRdata} !== {3'b000, 32'h00000080}) begin
            errors++;
            $display("[TB] FAIL late_rvalid: busy %b done %b fault %b rdata %h expected 0 0 0 00000080",
                     aBusy, aDone, aFault, aRdata);
        end
    endtask

    task automatic test_rv64;
        bIssue(3'b011, 32'h8);
        checks++;
        if ({bReq, bBe, bBusAddr} !== {1'b1, 8'hFF, 32'h8}) begin
            errors++;
            $display("[TB] FAIL ld_req: req %b be %h addr %h expected 1 ff 00000008", bReq, bBe, bBusAddr);
        end
        bBusCycle(64'h0123456789ABCDEF);
        checks++;
        if ({bDone, bFault, bRdata} !== {2'b10, 64'h0123456789ABCDEF}) begin
            errors++;
            $display("[TB] FAIL ld_data: done %b fault %b rdata %h expected 1 0 0123456789abcdef",
                     bDone, bFault, bRdata);
        end
        bIssue(3'b010, 32'hC);
        checks++;
        if ({bBe, bBusAddr} !== {8'hF0, 32'h8}) begin
            errors++;
            $display("[TB] FAIL lw64_be: be %h addr %h expected f0 00000008", bBe, bBusAddr);
        end
        bBusCycle(64'h89ABCDEF_00000000);
        checks++;
        if (bRdata !== 64'hFFFFFFFF89ABCDEF) begin
            errors++;
            $display("[TB] FAIL lw64_data: rdata %h expected ffffffff89abcdef", bRdata);
        end
        bIssue(3'b110, 32'hC);
        bBusCycle(64'h89ABCDEF_00000000);
        checks++;
        if (bRdata !== 64'h0000000089ABCDEF) begin
            errors++;
            $display("[TB] FAIL lwu64_data: rdata %h expected 0000000089abcdef", bRdata);
        end
        // Reset during RESP of a following LD
        bIssue(3'b011, 32'h10);
        bGnt = 1'b1;
        @(negedge clk);
        bGnt = 1'b0;
        bRstN = 1'b0;
        #1;
        checks++;
        if ({bReq, bBusy, bDone, bRdata} !== 67'b0) begin
            errors++;
            $display("[TB] FAIL reset_resp: req %b busy %b done %b rdata %h expected all 0",
                     bReq, bBusy, bDone, bRdata);
        end
        @(negedge clk);
        bRstN = 1'b1;
        bRvalid = 1'b1; bBusRdata = 64'hFFFF_0000_FFFF_0000;
        @(negedge clk);
        bRvalid = 1'b0;
        checks++;
        if ({bBusy, bDone, bRdata} !== 66'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_idle: busy %b done %b rdata %h expected all 0",
                     bBusy, bDone, bRdata);
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_byte();
        test_store_half();
        test_faults_at_accept();
        test_bus_error();
        test_timeout();
        test_rv64();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
